// File: rtl/traffic_light_monitor.sv
// Traffic light sequence/timing monitor: decodes observed lamp states, tracks
// phase order and phase durations, and reports sticky errors and completed cycles.
module traffic_light_monitor #(
    parameter int DUR_RED        = 5,
    parameter int DUR_RED_YELLOW = 5,
    parameter int DUR_GREEN      = 5,
    parameter int DUR_YELLOW     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        red,
    input  logic        yellow,
    input  logic        green,
    input  logic        clr_err,
    output logic [1:0]  phase,
    output logic        locked,
    output logic        seq_err,
    output logic        time_err,
    output logic        illegal_err,
    output logic        err_pulse,
    output logic        cycle_done,
    output logic [15:0] cycle_count,
    output logic [9:0]  last_dur
);

    localparam logic [1:0] PH_RED        = 2'b00;
    localparam logic [1:0] PH_RED_YELLOW = 2'b11;
    localparam logic [1:0] PH_GREEN      = 2'b01;
    localparam logic [1:0] PH_YELLOW     = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, TRACK = 2'd2} state_t;

    function automatic logic [9:0] sat_inc_dur(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [15:0] sat_inc_cnt(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [1:0] succ_of(input logic [1:0] p);
        case (p)
            PH_RED:        return PH_RED_YELLOW;
            PH_RED_YELLOW: return PH_GREEN;
            PH_GREEN:      return PH_YELLOW;
            default:       return PH_RED;
        endcase
    endfunction

    function automatic logic [9:0] dur_of(input logic [1:0] p);
        case (p)
            PH_RED:        return 10'(DUR_RED);
            PH_RED_YELLOW: return 10'(DUR_RED_YELLOW);
            PH_GREEN:      return 10'(DUR_GREEN);
            default:       return 10'(DUR_YELLOW);
        endcase
    endfunction

    state_t      state, nxt_state;
    logic [2:0]  code, prev_code;
    logic        prev_vld, prev_ill, overrun, armed;
    logic [9:0]  dur;
    logic        legal;
    logic [1:0]  dec;
    logic        changed, phase_adv, red_entry, close_cycle;
    logic        ev_seq, ev_time, ev_ill, ev_any, done;

    assign code    = {red, yellow, green};
    assign changed = !prev_vld || (code != prev_code);

    always_comb begin
        legal = 1'b1;
        dec   = PH_RED;
        case (code)
            3'b100:  dec = PH_RED;
            3'b110:  dec = PH_RED_YELLOW;
            3'b001:  dec = PH_GREEN;
            3'b010:  dec = PH_YELLOW;
            default: legal = 1'b0;
        endcase
    end

    // Outside IDLE the previous sample was legal, so a phase mismatch is a code change.
    always_comb begin
        nxt_state = state;
        ev_seq    = 1'b0;
        ev_time   = 1'b0;
        ev_ill    = 1'b0;
        phase_adv = 1'b0;
        if (!legal) begin
            nxt_state = IDLE;
            ev_ill    = !prev_ill;
        end else if (state == IDLE) begin
            nxt_state = SYNC;
        end else if (dec == phase) begin
            if (state == TRACK && dur == dur_of(phase) && !overrun)
                ev_time = 1'b1;
        end else if (dec == succ_of(phase)) begin
            phase_adv = 1'b1;
            nxt_state = TRACK;
            if (state == TRACK && dur != dur_of(phase) && !overrun)
                ev_time = 1'b1;
        end else begin
            ev_seq    = 1'b1;
            nxt_state = SYNC;
        end
    end

    assign ev_any      = ev_seq | ev_time | ev_ill;
    assign red_entry   = phase_adv && (dec == PH_RED);
    assign close_cycle = phase_adv && (state == TRACK) && (phase == PH_YELLOW);
    assign done        = close_cycle && armed && !ev_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= PH_RED;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
            time_err    <= 1'b0;
            illegal_err <= 1'b0;
            err_pulse   <= 1'b0;
            cycle_done  <= 1'b0;
            cycle_count <= 16'd0;
            last_dur    <= 10'd0;
            dur         <= 10'd0;
            prev_code   <= 3'b000;
            prev_vld    <= 1'b0;
            prev_ill    <= 1'b0;
            overrun     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state     <= nxt_state;
            locked    <= (nxt_state == TRACK);
            prev_code <= code;
            prev_vld  <= 1'b1;
            prev_ill  <= !legal;
            dur       <= changed ? 10'd1 : sat_inc_dur(dur);
            if (legal)
                phase <= dec;
            if (changed)
                overrun <= 1'b0;
            else if (ev_time)
                overrun <= 1'b1;
            // A cycle is armed at each RED entry and disarmed by any later error.
            if (red_entry)
                armed <= 1'b1;
            else if (ev_any)
                armed <= 1'b0;
            if (phase_adv && state == TRACK)
                last_dur <= dur;
            seq_err     <= (seq_err && !clr_err) || ev_seq;
            time_err    <= (time_err && !clr_err) || ev_time;
            illegal_err <= (illegal_err && !clr_err) || ev_ill;
            err_pulse   <= ev_any;
            cycle_done  <= done;
            if (done)
                cycle_count <= sat_inc_cnt(cycle_count);
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random lamp sequences
// compared every cycle against a phase-index reference model.
module tb_traffic_light_monitor;

    localparam int D_RED = 5, D_RY = 2, D_GREEN = 5, D_YELLOW = 3;

    logic        clk = 1'b0;
    logic        rst, red, yellow, green, clr_err;
    logic [1:0]  phase;
    logic        locked, seq_err, time_err, illegal_err, err_pulse, cycle_done;
    logic [15:0] cycle_count;
    logic [9:0]  last_dur;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .DUR_RED(D_RED), .DUR_RED_YELLOW(D_RY), .DUR_GREEN(D_GREEN), .DUR_YELLOW(D_YELLOW)
    ) dut (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green), .clr_err(clr_err),
        .phase(phase), .locked(locked), .seq_err(seq_err), .time_err(time_err),
        .illegal_err(illegal_err), .err_pulse(err_pulse), .cycle_done(cycle_done),
        .cycle_count(cycle_count), .last_dur(last_dur)
    );

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Phases as indices 0..3 in legal order; successor is (i+1) mod 4.
    int         dur_tab[4]  = '{D_RED, D_RY, D_GREEN, D_YELLOW};
    logic [1:0] enc_tab[4]  = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [2:0] code_tab[4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    logic [2:0] ill_tab[4]  = '{3'b000, 3'b011, 3'b101, 3'b111};

    bit         m_seen, m_timed, m_armed, m_over, m_prev_ill, m_have_prev;
    int         m_cur, m_run, m_count;
    logic [2:0] m_prev_code;
    bit         e_seq, e_time, e_ill, e_pulse, e_done;
    int         e_last;

    function automatic int code_idx(input logic [2:0] c);
        for (int i = 0; i < 4; i++)
            if (code_tab[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_seen = 0; m_timed = 0; m_armed = 0; m_over = 0; m_prev_ill = 0; m_have_prev = 0;
        m_cur = 0; m_run = 0; m_count = 0; m_prev_code = 3'b000;
        e_seq = 0; e_time = 0; e_ill = 0; e_pulse = 0; e_done = 0; e_last = 0;
    endtask

    task automatic model_step(input logic [2:0] c, input logic clr);
        int idx, prev_run;
        bit changed, ev_s, ev_t, ev_i, adv, closing;
        idx      = code_idx(c);
        changed  = !m_have_prev || (c != m_prev_code);
        prev_run = m_run;
        ev_s = 0; ev_t = 0; ev_i = 0; adv = 0; closing = 0;
        if (idx < 0) begin
            ev_i    = !m_prev_ill;
            m_seen  = 0;
            m_timed = 0;
        end else if (!m_seen) begin
            m_seen = 1;
            m_cur  = idx;
        end else if (idx == m_cur) begin
            if (m_timed && prev_run == dur_tab[m_cur] && !m_over) begin
                ev_t   = 1;
                m_over = 1;
            end
        end else if (idx == (m_cur + 1) % 4) begin
            adv = 1;
            if (m_timed) begin
                e_last  = prev_run;
                closing = (m_cur == 3);
                if (prev_run != dur_tab[m_cur] && !m_over) ev_t = 1;
            end
            m_timed = 1;
            m_cur   = idx;
        end else begin
            ev_s    = 1;
            m_timed = 0;
            m_cur   = idx;
        end
        e_pulse = ev_s | ev_t | ev_i;
        e_done  = closing && m_armed && !e_pulse;
        if (adv && idx == 0) m_armed = 1;
        else if (e_pulse)    m_armed = 0;
        if (e_done && m_count < 65535) m_count++;
        e_seq  = (e_seq && !clr) || ev_s;
        e_time = (e_time && !clr) || ev_t;
        e_ill  = (e_ill && !clr) || ev_i;
        if (changed) m_over = 0;
        m_run       = changed ? 1 : ((prev_run < 1023) ? prev_run + 1 : 1023);
        m_prev_code = c;
        m_have_prev = 1;
        m_prev_ill  = (idx < 0);
    endtask

    task automatic check_all();
        check("phase", 32'(phase), 32'(enc_tab[m_cur]));
        check("locked", 32'(locked), 32'(m_timed));
        check("seq_err", 32'(seq_err), 32'(e_seq));
        check("time_err", 32'(time_err), 32'(e_time));
        check("illegal_err", 32'(illegal_err), 32'(e_ill));
        check("err_pulse", 32'(err_pulse), 32'(e_pulse));
        check("cycle_done", 32'(cycle_done), 32'(e_done));
        check("cycle_count", 32'(cycle_count), 32'(m_count));
        check("last_dur", 32'(last_dur), 32'(e_last));
    endtask

    task automatic step(input logic [2:0] c, input logic clr_v, input logic rst_v);
        @(negedge clk);
        {red, yellow, green} = c;
        clr_err = clr_v;
        rst     = rst_v;
        @(posedge clk);
        if (rst_v) model_reset();
        else       model_step(c, clr_v);
        #1;
        check_all();
        if (cycle_done) n_done++;
    endtask

    task automatic hold(input int idx, input int len);
        repeat (len) step(code_tab[idx], 1'b0, 1'b0);
    endtask

    task automatic legal_cycle();
        for (int i = 0; i < 4; i++) hold(i, dur_tab[i]);
    endtask

    initial begin
        int s_idx, len, r;
        logic [2:0] c;
        rst = 1'b1; clr_err = 1'b0; {red, yellow, green} = 3'b000;
        model_reset();

        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);

        // clean sequence, several full cycles
        repeat (7) legal_cycle();
        check("clean_locked", 32'(locked), 32'd1);
        check("clean_errs", 32'({seq_err, time_err, illegal_err}), 32'd0);

        // short GREEN
        hold(0, D_RED); hold(1, D_RY); hold(2, 3); hold(3, 1);
        check("short_last_dur", 32'(last_dur), 32'd3);
        check("short_time_err", 32'(time_err), 32'd1);
        hold(3, D_YELLOW - 1);
        step(code_tab[0], 1'b1, 1'b0);
        hold(0, D_RED - 1);

        // long GREEN
        hold(1, D_RY); hold(2, 7); hold(3, 1);
        check("long_last_dur", 32'(last_dur), 32'd7);
        hold(3, D_YELLOW - 1);
        legal_cycle();

        // GREEN -> RED skip, then relock
        hold(0, D_RED); hold(1, D_RY); hold(2, D_GREEN); hold(0, 1);
        check("skip_seq_err", 32'(seq_err), 32'd1);
        check("skip_locked", 32'(locked), 32'd0);
        hold(0, D_RED - 1); hold(1, D_RY);
        check("relock", 32'(locked), 32'd1);
        hold(2, D_GREEN); hold(3, D_YELLOW);

        // illegal 111 x2, then seq error with simultaneous clear
        step(3'b111, 1'b1, 1'b0);
        step(3'b111, 1'b0, 1'b0);
        check("ill_flag", 32'(illegal_err), 32'd1);
        hold(2, 2);
        step(code_tab[0], 1'b1, 1'b0);
        check("clr_vs_seq", 32'(seq_err), 32'd1);
        hold(0, D_RED); legal_cycle();

        // reset in mid-GREEN
        hold(1, D_RY); hold(2, 2);
        step(code_tab[2], 1'b0, 1'b1);
        check("rst_count", 32'(cycle_count), 32'd0);
        hold(2, 3); hold(3, D_YELLOW); legal_cycle(); legal_cycle();

        // random sequences
        s_idx = 0;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 94) begin
                if (r < 65) begin
                    s_idx = (s_idx + 1) % 4; len = dur_tab[s_idx];
                end else if (r < 78) begin
                    s_idx = (s_idx + 1) % 4; len = $urandom_range(1, 8);
                end else if (r < 86) begin
                    s_idx = $urandom_range(0, 3); len = $urandom_range(1, 6);
                end else begin
                    len = $urandom_range(1, 3);
                end
                c = (r < 86) ? code_tab[s_idx] : ill_tab[$urandom_range(0, 3)];
                for (int k = 0; k < len; k++)
                    step(c, ($urandom_range(0, 9) == 0), 1'b0);
            end else begin
                repeat ($urandom_range(1, 2)) step(code_tab[s_idx], 1'b0, 1'b1);
            end
        end

        // counter saturation
        step(3'b000, 1'b0, 1'b1);
        force dut.cycle_count = 16'd65534;
        m_count = 65534;
        step(code_tab[0], 1'b0, 1'b0);
        release dut.cycle_count;
        hold(0, D_RED - 1); hold(1, D_RY); hold(2, D_GREEN); hold(3, D_YELLOW);
        n_done = 0;
        legal_cycle(); legal_cycle(); legal_cycle();
        check("sat_count", 32'(cycle_count), 32'd65535);
        check("sat_pulses", 32'(n_done), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
